// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU control FSM
// Sequences fetch/decode/exec/mem/writeback from decoded flags and counts retires and memory stalls.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  logic        dec_memread,
    input  logic        dec_memwrite,
    input  logic        dec_jump,
    input  logic        dec_isjal,
    input  logic        dec_branch,
    input  logic        dec_regwrite,
    input  logic        dec_jr,
    input  logic        dec_halt,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        ir_load,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        rf_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] instr_count,
    output logic [15:0] wait_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    state_t state_q;
    state_t state_d;
    logic   retire;
    logic   set_illegal;
    logic   wait_event;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        ir_load     = 1'b0;
        pc_we       = 1'b0;
        pc_src      = PC_SEQ;
        rf_we       = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!dec_valid) begin
                    set_illegal = 1'b1;
                    state_d     = S_HALT;
                end else if (dec_halt) begin
                    state_d = S_HALT;
                end else if (dec_jump) begin
                    pc_we   = 1'b1;
                    pc_src  = PC_JUMP;
                    rf_we   = dec_isjal;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (dec_branch) begin
                    pc_we   = 1'b1;
                    pc_src  = branch_taken ? PC_BRANCH : PC_SEQ;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (dec_jr) begin
                    pc_we   = 1'b1;
                    pc_src  = PC_RS;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (dec_memread || dec_memwrite) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_memwrite;
                if (dmem_ready) begin
                    // Stores finish here; loads still need writeback.
                    if (dec_memwrite) begin
                        pc_we   = 1'b1;
                        pc_src  = PC_SEQ;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = dec_regwrite;
                pc_we   = 1'b1;
                pc_src  = PC_SEQ;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                set_illegal = 1'b1;
                state_d     = S_HALT;
            end
        endcase

        // Reset abandons whatever is in flight, including a pending memory access.
        if (rst) begin
            imem_req    = 1'b0;
            ir_load     = 1'b0;
            pc_we       = 1'b0;
            pc_src      = PC_SEQ;
            rf_we       = 1'b0;
            dmem_req    = 1'b0;
            dmem_we     = 1'b0;
            retire      = 1'b0;
            set_illegal = 1'b0;
        end
    end

    assign wait_event = (imem_req & ~imem_ready) | (dmem_req & ~dmem_ready);
    assign state      = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            halted      <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= 32'd0;
            wait_count  <= 16'd0;
        end else begin
            if (state_d == S_HALT) begin
                halted <= 1'b1;
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (retire) begin
                instr_count <= instr_count + 32'd1;
            end
            if (wait_event && (wait_count != 16'hFFFF)) begin
                wait_count <= wait_count + 16'd1;
            end
        end
    end

endmodule
